// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU pipeline and an external host.
// The CPU has priority, but a pending host access is deferred by at most HOST_MAX_WAIT CPU accesses.
module dmem_arbiter #(
  parameter int HOST_MAX_WAIT = 4,
  parameter int AW            = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_stall,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [31:0]   host_addr,
  input  logic [31:0]   host_wdata,
  output logic          host_busy,
  output logic          host_ack,
  output logic [31:0]   host_rdata,
  output logic          host_rvalid,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int WW = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, PEND, HRD} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            hwe_q, hwe_d;
  logic [AW-1:0]   haddr_q, haddr_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic            cpuRd_q, cpuRd_d;
  logic            hostRd_q, hostRd_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic            hostGrant;
  logic            cpuGrant;
  logic            unusedBits;

  assign unusedBits = ^{cpu_addr[1:0], host_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    hwe_d     = hwe_q;
    haddr_d   = haddr_q;
    hwdata_d  = hwdata_q;
    cpuRd_d   = 1'b0;
    hostRd_d  = 1'b0;
    hrdata_d  = hrdata_q;
    hostGrant = 1'b0;
    cpuGrant  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = cpu_addr[AW+1:2];
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    host_ack  = 1'b0;

    if (!reset) begin
      hostGrant = (state_q == PEND) && (!cpu_req || (wait_q == WAIT_MAX));
      cpuGrant  = cpu_req && !hostGrant;

      case (state_q)
        IDLE: begin
          wait_d = '0;
          if (host_req) begin
            hwe_d    = host_we;
            haddr_d  = host_addr[AW+1:2];
            hwdata_d = host_wdata;
            state_d  = PEND;
          end
        end
        PEND: begin
          if (hostGrant) begin
            wait_d  = '0;
            state_d = hwe_q ? IDLE : HRD;
          end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
          end
        end
        HRD:     state_d = IDLE;
        default: state_d = IDLE;
      endcase

      // The owner tag remembers who issued a read so next cycle's mem_rdata goes to the right requester.
      if (hostGrant) begin
        mem_en    = 1'b1;
        mem_we    = {4{hwe_q}};
        mem_addr  = haddr_q;
        mem_wdata = hwdata_q;
        host_ack  = 1'b1;
        cpu_stall = cpu_req;
        hostRd_d  = !hwe_q;
      end else if (cpuGrant) begin
        mem_en  = 1'b1;
        mem_we  = cpu_we;
        cpuRd_d = (cpu_we == 4'b0000);
      end

      if (hostRd_q) begin
        hrdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      hwe_q    <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      cpuRd_q  <= 1'b0;
      hostRd_q <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      hwe_q    <= hwe_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      cpuRd_q  <= cpuRd_d;
      hostRd_q <= hostRd_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Read returns are masked while reset is high so an in-flight access is silently dropped.
  assign cpu_rvalid  = cpuRd_q && !reset;
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : 32'h0;
  assign host_rvalid = hostRd_q && !reset;
  assign host_rdata  = reset ? 32'h0 : (host_rvalid ? mem_rdata : hrdata_q);
  assign host_busy   = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural memory, a shadow reference memory,
// and read-return scoreboards for the CPU and host ports.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_busy;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] mem    [0:255];
  logic [31:0] refMem [0:255];
  logic [31:0] cpuExpQ[$];
  logic [31:0] hostExpQ[$];

  dmem_arbiter #(.HOST_MAX_WAIT(4), .AW(30)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Read-return monitor: every rvalid pulse must match the oldest expected value.
  always @(negedge clk) begin
    logic [31:0] exp;
    #2;
    if (cpu_rvalid) begin
      checkCount++;
      if (cpuExpQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL cpu_rvalid_unexpected: got rdata %h with no read outstanding", cpu_rdata);
      end else begin
        exp = cpuExpQ.pop_front();
        if (cpu_rdata !== exp) begin
          errorCount++;
          $display("[TB] FAIL cpu_rdata: got %h expected %h", cpu_rdata, exp);
        end
      end
    end
    if (host_rvalid) begin
      checkCount++;
      if (hostExpQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL host_rvalid_unexpected: got rdata %h with no read outstanding", host_rdata);
      end else begin
        exp = hostExpQ.pop_front();
        if (host_rdata !== exp) begin
          errorCount++;
          $display("[TB] FAIL host_rdata: got %h expected %h", host_rdata, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    cpu_req = 1'b0; cpu_we = 4'b0000; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
  endtask

  task automatic refWrite(input logic [31:0] byteAddr, input logic [3:0] mask, input logic [31:0] data);
    for (int b = 0; b < 4; b++)
      if (mask[b]) refMem[byteAddr[9:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic cpuDrive(input logic [31:0] byteAddr, input logic [3:0] mask, input logic [31:0] data);
    cpu_req = 1'b1; cpu_we = mask; cpu_addr = byteAddr; cpu_wdata = data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpuDrive(32'h40, 4'b0000, 32'h0);
    host_req = 1'b1; host_addr = 32'h10;
    tick();
    tick();
    #1;
    checkCount++; if (mem_en !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); end
    checkCount++; if (mem_we !== 4'b0000) begin errorCount++; $display("[TB] FAIL reset_mem_we: got %b expected 0000", mem_we); end
    checkCount++; if (cpu_stall !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
    checkCount++; if (host_busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_host_busy: got %b expected 0", host_busy); end
    checkCount++; if (host_ack !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_host_ack: got %b expected 0", host_ack); end
    checkCount++; if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_rvalid: got cpu %b host %b expected 0 0", cpu_rvalid, host_rvalid); end
    checkCount++; if (host_rdata !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_host_rdata: got %h expected 0", host_rdata); end
    idleInputs();
    reset = 1'b0;
    tick();
    #1;
    checkCount++; if (host_busy !== 1'b0) begin errorCount++; $display("[TB] FAIL post_reset_busy: got %b expected 0", host_busy); end
    tick();
  endtask

  task automatic test_host_write();
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'hDEADBEEF;
    refWrite(32'h10, 4'b1111, 32'hDEADBEEF);
    #1;
    checkCount++; if (host_ack !== 1'b0 || host_busy !== 1'b0) begin errorCount++; $display("[TB] FAIL hw_latch_cycle: got ack %b busy %b expected 0 0", host_ack, host_busy); end
    tick();
    host_req = 1'b0;
    #1;
    checkCount++; if (host_ack !== 1'b1) begin errorCount++; $display("[TB] FAIL hw_ack: got %b expected 1", host_ack); end
    checkCount++; if (mem_en !== 1'b1 || mem_we !== 4'b1111) begin errorCount++; $display("[TB] FAIL hw_mem_ctrl: got en %b we %b expected 1 1111", mem_en, mem_we); end
    checkCount++; if (mem_addr !== 30'd4) begin errorCount++; $display("[TB] FAIL hw_mem_addr: got %h expected 4", mem_addr); end
    checkCount++; if (mem_wdata !== 32'hDEADBEEF) begin errorCount++; $display("[TB] FAIL hw_mem_wdata: got %h expected deadbeef", mem_wdata); end
    checkCount++; if (host_busy !== 1'b1 || cpu_stall !== 1'b0) begin errorCount++; $display("[TB] FAIL hw_busy_stall: got busy %b stall %b expected 1 0", host_busy, cpu_stall); end
    tick();
    #1;
    checkCount++; if (host_busy !== 1'b0 || host_ack !== 1'b0) begin errorCount++; $display("[TB] FAIL hw_release: got busy %b ack %b expected 0 0", host_busy, host_ack); end
    tick();
  endtask

  task automatic test_host_read();
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h10;
    tick();
    host_req = 1'b0;
    #1;
    checkCount++; if (host_ack !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0000) begin errorCount++; $display("[TB] FAIL hr_issue: got ack %b en %b we %b expected 1 1 0000", host_ack, mem_en, mem_we); end
    checkCount++; if (mem_addr !== 30'd4) begin errorCount++; $display("[TB] FAIL hr_mem_addr: got %h expected 4", mem_addr); end
    hostExpQ.push_back(refMem[4]);
    tick();
    #1;
    checkCount++; if (host_rvalid !== 1'b1 || host_busy !== 1'b1) begin errorCount++; $display("[TB] FAIL hr_return: got rvalid %b busy %b expected 1 1", host_rvalid, host_busy); end
    checkCount++; if (host_rdata !== 32'hDEADBEEF) begin errorCount++; $display("[TB] FAIL hr_data: got %h expected deadbeef", host_rdata); end
    tick();
    #1;
    checkCount++; if (host_busy !== 1'b0 || host_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL hr_release: got busy %b rvalid %b expected 0 0", host_busy, host_rvalid); end
    checkCount++; if (host_rdata !== 32'hDEADBEEF) begin errorCount++; $display("[TB] FAIL hr_hold: got %h expected deadbeef", host_rdata); end
    tick();
  endtask

  task automatic test_cpu_rw();
    logic [3:0] masks [4];
    masks[0] = 4'b1111; masks[1] = 4'b0011; masks[2] = 4'b1100; masks[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cpuDrive(32'h40 + 32'(4*i), masks[i], 32'hC0DE0000 + 32'(i) * 32'h11111111);
      refWrite(32'h40 + 32'(4*i), masks[i], 32'hC0DE0000 + 32'(i) * 32'h11111111);
      #1;
      checkCount++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== masks[i]) begin errorCount++; $display("[TB] FAIL cw_issue%0d: got stall %b en %b we %b expected 0 1 %b", i, cpu_stall, mem_en, mem_we, masks[i]); end
      tick();
      #1;
      checkCount++; if (cpu_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL cw_no_rvalid%0d: got %b expected 0", i, cpu_rvalid); end
    end
    for (int i = 0; i < 4; i++) begin
      cpuDrive(32'h40 + 32'(4*i), 4'b0000, 32'h0);
      cpuExpQ.push_back(refMem[8'h10 + 8'(i)]);
      #1;
      checkCount++; if (cpu_rvalid !== (i > 0)) begin errorCount++; $display("[TB] FAIL cr_pipeline%0d: got rvalid %b expected %b", i, cpu_rvalid, (i > 0)); end
      tick();
    end
    idleInputs();
    #1;
    checkCount++; if (cpu_rvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL cr_last_rvalid: got %b expected 1", cpu_rvalid); end
    tick();
    #1;
    checkCount++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errorCount++; $display("[TB] FAIL cr_idle_rdata: got rvalid %b rdata %h expected 0 0", cpu_rvalid, cpu_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    int stallCycles = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h44;
    cpuDrive(32'h40, 4'b0000, 32'h0);
    cpuExpQ.push_back(refMem[8'h10]);
    tick();
    host_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpuDrive(32'h40 + 32'(4*k), 4'b0000, 32'h0);
      #1;
      if (cpu_stall === 1'b1) stallCycles++;
      checkCount++; if (host_ack !== 1'b0 || cpu_stall !== 1'b0) begin errorCount++; $display("[TB] FAIL starve_cpu_grant%0d: got ack %b stall %b expected 0 0", k, host_ack, cpu_stall); end
      checkCount++; if (mem_addr !== 30'h10 + 30'(k)) begin errorCount++; $display("[TB] FAIL starve_cpu_addr%0d: got %h expected %h", k, mem_addr, 30'h10 + 30'(k)); end
      cpuExpQ.push_back(refMem[8'h10 + 8'(k)]);
      tick();
    end
    cpuDrive(32'h48, 4'b0000, 32'h0);
    #1;
    if (cpu_stall === 1'b1) stallCycles++;
    checkCount++; if (host_ack !== 1'b1 || cpu_stall !== 1'b1) begin errorCount++; $display("[TB] FAIL starve_host_grant: got ack %b stall %b expected 1 1", host_ack, cpu_stall); end
    checkCount++; if (mem_addr !== 30'h11 || mem_we !== 4'b0000) begin errorCount++; $display("[TB] FAIL starve_host_addr: got %h we %b expected 11 0000", mem_addr, mem_we); end
    hostExpQ.push_back(refMem[8'h11]);
    tick();
    #1;
    if (cpu_stall === 1'b1) stallCycles++;
    checkCount++; if (host_rvalid !== 1'b1 || mem_addr !== 30'h12) begin errorCount++; $display("[TB] FAIL starve_hrd: got rvalid %b addr %h expected 1 12", host_rvalid, mem_addr); end
    cpuExpQ.push_back(refMem[8'h12]);
    tick();
    idleInputs();
    #1;
    checkCount++; if (stallCycles != 1) begin errorCount++; $display("[TB] FAIL starve_stall_count: got %0d expected 1", stallCycles); end
    checkCount++; if (host_busy !== 1'b0) begin errorCount++; $display("[TB] FAIL starve_release: got busy %b expected 0", host_busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h4C;
    tick();
    host_req = 1'b0;
    #1;
    checkCount++; if (host_ack !== 1'b1) begin errorCount++; $display("[TB] FAIL b2b_ack: got %b expected 1", host_ack); end
    hostExpQ.push_back(refMem[8'h13]);
    tick();
    cpuDrive(32'h40, 4'b0000, 32'h0);
    cpuExpQ.push_back(refMem[8'h10]);
    #1;
    checkCount++; if (host_rvalid !== 1'b1 || cpu_stall !== 1'b0 || mem_en !== 1'b1) begin errorCount++; $display("[TB] FAIL b2b_hrd: got rvalid %b stall %b en %b expected 1 0 1", host_rvalid, cpu_stall, mem_en); end
    checkCount++; if (cpu_rvalid !== 1'b0 || mem_addr !== 30'h10) begin errorCount++; $display("[TB] FAIL b2b_cpu_issue: got rvalid %b addr %h expected 0 10", cpu_rvalid, mem_addr); end
    tick();
    idleInputs();
    #1;
    checkCount++; if (cpu_rvalid !== 1'b1 || host_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_route: got cpu %b host %b expected 1 0", cpu_rvalid, host_rvalid); end
    checkCount++; if (host_rdata !== refMem[8'h13]) begin errorCount++; $display("[TB] FAIL b2b_host_hold: got %h expected %h", host_rdata, refMem[8'h13]); end
    tick();
  endtask

  task automatic test_busy_ignore();
    int ackCount = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h50; host_wdata = 32'h12345678;
    cpuDrive(32'h60, 4'b1111, 32'h60000000);
    refWrite(32'h60, 4'b1111, 32'h60000000);
    refWrite(32'h50, 4'b1111, 32'h12345678);
    tick();
    host_addr = 32'h54; host_wdata = 32'hBAD0BAD0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 4) begin
        cpuDrive(32'h60, 4'b1111, 32'h60000000 + 32'(k));
        refWrite(32'h60, 4'b1111, 32'h60000000 + 32'(k));
      end else begin
        cpu_req = 1'b0; cpu_we = 4'b0000;
        host_req = 1'b0;
      end
      #1;
      if (host_ack === 1'b1) begin
        ackCount++;
        checkCount++; if (k != 5 || mem_addr !== 30'h14 || mem_wdata !== 32'h12345678) begin errorCount++; $display("[TB] FAIL busy_ack_content: cycle %0d addr %h data %h expected cycle 5 addr 14 data 12345678", k, mem_addr, mem_wdata); end
      end
      tick();
    end
    checkCount++; if (ackCount != 1) begin errorCount++; $display("[TB] FAIL busy_ack_count: got %0d expected 1", ackCount); end
    for (int i = 0; i < 3; i++) begin
      cpuDrive(32'h50 + 32'(i == 2 ? 16 : 4*i), 4'b0000, 32'h0);
      cpuExpQ.push_back(refMem[8'h14 + 8'(i == 2 ? 4 : i)]);
      tick();
    end
    idleInputs();
    tick();
    tick();
  endtask

  task automatic test_reset_in_pend();
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    cpuDrive(32'h40, 4'b0000, 32'h0);
    cpuExpQ.push_back(refMem[8'h10]);
    tick();
    host_req = 1'b0;
    cpuDrive(32'h44, 4'b0000, 32'h0);
    #1;
    checkCount++; if (host_busy !== 1'b1 || host_ack !== 1'b0) begin errorCount++; $display("[TB] FAIL rp_pending: got busy %b ack %b expected 1 0", host_busy, host_ack); end
    tick();
    reset = 1'b1;
    #1;
    checkCount++; if (host_ack !== 1'b0 || mem_en !== 1'b0 || cpu_stall !== 1'b0) begin errorCount++; $display("[TB] FAIL rp_during: got ack %b en %b stall %b expected 0 0 0", host_ack, mem_en, cpu_stall); end
    checkCount++; if (cpu_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL rp_inflight_rvalid: got %b expected 0", cpu_rvalid); end
    tick();
    reset = 1'b0;
    idleInputs();
    #1;
    checkCount++; if (host_busy !== 1'b0 || host_ack !== 1'b0 || host_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL rp_after: got busy %b ack %b hrv %b crv %b expected 0 0 0 0", host_busy, host_ack, host_rvalid, cpu_rvalid); end
    checkCount++; if (host_rdata !== 32'h0 || mem_en !== 1'b0) begin errorCount++; $display("[TB] FAIL rp_after_data: got rdata %h en %b expected 0 0", host_rdata, mem_en); end
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      checkCount++; if (host_ack !== 1'b0) begin errorCount++; $display("[TB] FAIL rp_late_ack%0d: got %b expected 0", k, host_ack); end
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h10000000 | 32'(i);
      refMem[i] = 32'h10000000 | 32'(i);
    end
    idleInputs();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_host_write();
    test_host_read();
    test_cpu_rw();
    test_starvation();
    test_back_to_back();
    test_busy_ignore();
    test_reset_in_pend();
    tick();
    checkCount++;
    if (cpuExpQ.size() != 0 || hostExpQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d cpu and %0d host reads outstanding expected 0 0", cpuExpQ.size(), hostExpQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
